// File: rtl/px_subsampler_2d_if.sv
`default_nettype none
// ============================================================================
// Module      : px_subsampler_2d_if
// Description : AXI4-Stream video beat bundle (one pixel per beat).
//               master drives tdata/tvalid/tlast/tuser and samples tready;
//               slave is the mirror image.
// Ports       : tdata  - pixel data, TDATA_WIDTH bits
//               tvalid - beat valid
//               tlast  - end of line
//               tuser  - start of frame
//               tready - sink ready
// Revision    : 1.0 - initial release
// ============================================================================
interface px_subsampler_2d_if #(
  parameter int TDATA_WIDTH = 32
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tuser;
  logic                   tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/px_subsampler_2d.sv
`default_nettype none
// ============================================================================
// Module      : px_subsampler_2d
// Description : Two-dimensional multi-channel pixel subsampler on an
//               AXI4-Stream video path. Horizontal and vertical ratios are
//               independent powers of two; horizontal reduction is either
//               drop (first pixel of each group) or box average.
// Ports       : clk_i          - clock
//               rst_i          - asynchronous active-high reset
//               ratio_x_log2_i - horizontal ratio exponent (latched on SOF)
//               ratio_y_log2_i - vertical ratio exponent (latched on SOF)
//               avg_en_i       - 0 = horizontal drop, 1 = horizontal average
//               video_i        - input stream (slave modport)
//               video_o        - output stream (master modport)
// Revision    : 1.0 - initial release
// ============================================================================
module px_subsampler_2d #(
  parameter int CHANNELS_AMOUNT = 3,
  parameter int PX_WIDTH        = 10,
  parameter int MAX_RATIO_LOG2  = 2,
  parameter int TDATA_WIDTH     = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [$clog2(MAX_RATIO_LOG2+1)-1:0]   ratio_x_log2_i,
  input  logic [$clog2(MAX_RATIO_LOG2+1)-1:0]   ratio_y_log2_i,
  input  logic                                  avg_en_i,
  px_subsampler_2d_if.slave                     video_i,
  px_subsampler_2d_if.master                    video_o
);

  localparam int c_RW     = $clog2(MAX_RATIO_LOG2+1);
  localparam int c_CW     = (MAX_RATIO_LOG2 < 1) ? 1 : MAX_RATIO_LOG2;
  localparam int c_DATA_W = CHANNELS_AMOUNT * PX_WIDTH;
  localparam int c_ACC_W  = PX_WIDTH + MAX_RATIO_LOG2;

  // --------------------------------------------------------------------------
  // Active (per-frame) configuration
  // --------------------------------------------------------------------------
  logic [c_RW-1:0] r_rx;
  logic [c_RW-1:0] r_ry;
  logic            r_avg;

  // Stream state
  logic [c_CW-1:0] r_x_cnt;
  logic [c_CW-1:0] r_y_cnt;
  logic            r_sof_pend;

  // Output register
  logic                   r_o_valid;
  logic                   r_o_last;
  logic                   r_o_user;
  logic [TDATA_WIDTH-1:0] r_o_data;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic            w_ready;
  logic            w_accept;
  logic [c_RW-1:0] w_rx_sat;
  logic [c_RW-1:0] w_ry_sat;
  logic [c_RW-1:0] w_rx;
  logic [c_RW-1:0] w_ry;
  logic            w_avg;
  logic [c_CW-1:0] w_x_cur;
  logic [c_CW-1:0] w_y_cur;
  logic [c_CW-1:0] w_x_mask;
  logic [c_CW-1:0] w_y_mask;
  logic            w_x_last;
  logic            w_grp_first;
  logic            w_kept;
  logic            w_close;
  logic            w_emit;
  logic            w_full_avg;

  logic [PX_WIDTH-1:0]    w_out_px [CHANNELS_AMOUNT];
  logic [TDATA_WIDTH-1:0] w_out_data;

  // Ready depends only on the output register and downstream ready, never on
  // the input valid, so no combinational valid->ready path exists.
  assign w_ready  = !r_o_valid || video_o.tready;
  assign w_accept = video_i.tvalid && w_ready;

  // Out-of-range exponents clamp to the largest supported ratio.
  assign w_rx_sat = (ratio_x_log2_i > c_RW'(MAX_RATIO_LOG2)) ? c_RW'(MAX_RATIO_LOG2) : ratio_x_log2_i;
  assign w_ry_sat = (ratio_y_log2_i > c_RW'(MAX_RATIO_LOG2)) ? c_RW'(MAX_RATIO_LOG2) : ratio_y_log2_i;

  // A start-of-frame beat is processed with the freshly latched config and
  // with counters already restarted, so a short line or stale group before
  // it cannot leak into the new frame.
  assign w_rx    = video_i.tuser ? w_rx_sat : r_rx;
  assign w_ry    = video_i.tuser ? w_ry_sat : r_ry;
  assign w_avg   = video_i.tuser ? avg_en_i : r_avg;
  assign w_x_cur = video_i.tuser ? '0 : r_x_cnt;
  assign w_y_cur = video_i.tuser ? '0 : r_y_cnt;

  // Counter wrap masks: 2^r - 1 expressed as r low ones.
  always_comb begin
    w_x_mask = '0;
    w_y_mask = '0;
    for (int i = 0; i < c_CW; i++) begin
      if (i < int'(w_rx)) w_x_mask[i] = 1'b1;
      if (i < int'(w_ry)) w_y_mask[i] = 1'b1;
    end
  end

  assign w_x_last    = (w_x_cur == w_x_mask);
  assign w_grp_first = (w_x_cur == '0);
  assign w_kept      = (w_y_cur == '0);
  assign w_close     = w_kept && (w_x_last || video_i.tlast);
  assign w_emit      = w_accept && w_close;
  // Only a complete group is averaged; a group cut short by tlast falls back
  // to its first pixel.
  assign w_full_avg  = w_avg && w_x_last;

  // --------------------------------------------------------------------------
  // Per-channel datapath
  // --------------------------------------------------------------------------
  generate
    for (genvar c = 0; c < CHANNELS_AMOUNT; c++) begin : g_ch
      logic [PX_WIDTH-1:0] w_px;
      logic [PX_WIDTH-1:0] w_first_px;
      logic [PX_WIDTH-1:0] w_avg_px;
      logic [c_ACC_W-1:0] w_acc_base;
      logic [c_ACC_W-1:0] w_sum;
      logic [c_ACC_W-1:0] r_acc;
      logic [PX_WIDTH-1:0] r_first;

      assign w_px       = video_i.tdata[c*PX_WIDTH +: PX_WIDTH];
      assign w_first_px = w_grp_first ? w_px : r_first;
      // Accumulator restarts at the first beat of each group.
      assign w_acc_base = w_grp_first ? '0 : r_acc;
      assign w_sum      = w_acc_base + c_ACC_W'(w_px);
      // Truncating divide by the group size.
      assign w_avg_px   = PX_WIDTH'(w_sum >> w_rx);
      assign w_out_px[c] = w_full_avg ? w_avg_px : w_first_px;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_acc   <= '0;
          r_first <= '0;
        end else if (w_accept) begin
          r_acc   <= w_sum;
          r_first <= w_first_px;
        end
      end

      assign w_out_data[c*PX_WIDTH +: PX_WIDTH] = w_out_px[c];
    end

    if (TDATA_WIDTH > c_DATA_W) begin : g_pad
      logic w_unused_tdata;
      assign w_out_data[TDATA_WIDTH-1:c_DATA_W] = '0;
      assign w_unused_tdata = ^video_i.tdata[TDATA_WIDTH-1:c_DATA_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Configuration, counters and pending start-of-frame
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx       <= '0;
      r_ry       <= '0;
      r_avg      <= 1'b0;
      r_x_cnt    <= '0;
      r_y_cnt    <= '0;
      r_sof_pend <= 1'b0;
    end else if (w_accept) begin
      if (video_i.tuser) begin
        r_rx  <= w_rx_sat;
        r_ry  <= w_ry_sat;
        r_avg <= avg_en_i;
      end

      if (video_i.tlast || w_x_last) begin
        r_x_cnt <= '0;
      end else begin
        r_x_cnt <= w_x_cur + c_CW'(1);
      end

      if (video_i.tlast) begin
        r_y_cnt <= (w_y_cur + c_CW'(1)) & w_y_mask;
      end else begin
        r_y_cnt <= w_y_cur;
      end

      // SOF stays pending across dropped lines/beats until it rides out on
      // the first emitted beat.
      if (w_close) begin
        r_sof_pend <= 1'b0;
      end else if (video_i.tuser) begin
        r_sof_pend <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register: loads whenever it is empty or being drained this cycle,
  // otherwise holds its contents stable.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;
      r_o_user  <= 1'b0;
      r_o_data  <= '0;
    end else if (w_ready) begin
      r_o_valid <= w_emit;
      if (w_emit) begin
        r_o_data <= w_out_data;
        r_o_last <= video_i.tlast;
        r_o_user <= video_i.tuser || r_sof_pend;
      end
    end
  end

  assign video_i.tready = w_ready;
  assign video_o.tvalid = r_o_valid;
  assign video_o.tdata  = r_o_data;
  assign video_o.tlast  = r_o_last;
  assign video_o.tuser  = r_o_user;

endmodule
`default_nettype wire

// File: tb/tb_px_subsampler_2d.sv
`default_nettype none
// ============================================================================
// Module      : tb_px_subsampler_2d
// Description : Directed self-checking bench for px_subsampler_2d.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_px_subsampler_2d;

  localparam int CH   = 3;
  localparam int PXW  = 10;
  localparam int MAXR = 2;
  localparam int TDW  = 32;

  typedef struct packed {
    logic [TDW-1:0] d;
    logic           l;
    logic           u;
  } beat_t;

  logic       clk;
  logic       rst;
  logic [1:0] ratio_x;
  logic [1:0] ratio_y;
  logic       avg_en;

  px_subsampler_2d_if #(.TDATA_WIDTH(TDW)) vi ();
  px_subsampler_2d_if #(.TDATA_WIDTH(TDW)) vo ();

  px_subsampler_2d #(
    .CHANNELS_AMOUNT (CH),
    .PX_WIDTH        (PXW),
    .MAX_RATIO_LOG2  (MAXR),
    .TDATA_WIDTH     (TDW)
  ) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ratio_x_log2_i (ratio_x),
    .ratio_y_log2_i (ratio_y),
    .avg_en_i       (avg_en),
    .video_i        (vi),
    .video_o        (vo)
  );

  beat_t exp_q[$];
  beat_t got_q[$];
  int    in_cyc_q[$];
  int    out_cyc_q[$];
  int    cyc;
  int    n_checks;
  int    n_fail;
  bit    bp_mode;
  bit    rand_gaps;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [TDW-1:0] pk(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    return {2'b00, c, b, a};
  endfunction

  task automatic push_exp(input logic [TDW-1:0] d, input logic l, input logic u);
    beat_t b;
    b.d = d;
    b.l = l;
    b.u = u;
    exp_q.push_back(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [TDW-1:0] d, input logic l, input logic u);
    bit ok;
    ok = 1'b0;
    vi.tdata  = d;
    vi.tlast  = l;
    vi.tuser  = u;
    vi.tvalid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = vi.tready;
      if (ok) in_cyc_q.push_back(cyc);
      @(posedge clk);
      #1;
    end
    vi.tvalid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    if (rand_gaps) idle($urandom_range(0, 2));
  endtask

  task automatic start_test;
    exp_q.delete();
    got_q.delete();
    in_cyc_q.delete();
    out_cyc_q.delete();
  endtask

  task automatic finish_test(input string name);
    for (int t = 0; t < 400 && got_q.size() < exp_q.size(); t++) @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_data%0d", name, i), got_q[i].d, exp_q[i].d);
      chk($sformatf("%s_last%0d", name, i), {31'd0, got_q[i].l}, {31'd0, exp_q[i].l});
      chk($sformatf("%s_user%0d", name, i), {31'd0, got_q[i].u}, {31'd0, exp_q[i].u});
    end
  endtask

  // 8x4 frame, pixel y*8+x (channels offset by 0/1/2); 2x2 drop keeps
  // even pixels of lines 0 and 2.
  task automatic frame_2x2;
    int v;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        v = y * 8 + x;
        send(pk(10'(v), 10'(v + 1), 10'(v + 2)), x == 7, (y == 0) && (x == 0));
        if ((y % 2 == 0) && (x % 2 == 0))
          push_exp(pk(10'(v), 10'(v + 1), 10'(v + 2)), x == 6, (y == 0) && (x == 0));
      end
    end
  endtask

  // Output monitor: records transfers and checks that a stalled beat is held.
  initial begin : p_mon
    beat_t          b;
    logic           stall;
    logic [TDW-1:0] hd;
    logic [1:0]     hlu;
    stall = 1'b0;
    hd    = '0;
    hlu   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", {31'd0, vo.tvalid}, 32'd1);
          chk("hold_data", vo.tdata, hd);
          chk("hold_last_user", {30'd0, vo.tlast, vo.tuser}, {30'd0, hlu});
        end
        if (vo.tvalid && vo.tready) begin
          b.d = vo.tdata;
          b.l = vo.tlast;
          b.u = vo.tuser;
          got_q.push_back(b);
          out_cyc_q.push_back(cyc);
        end
        stall = vo.tvalid && !vo.tready;
        hd    = vo.tdata;
        hlu   = {vo.tlast, vo.tuser};
      end
    end
  end

  // Downstream ready toggles every cycle while backpressure is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) vo.tready = ~vo.tready;
    end
  end

  initial begin
    logic [9:0] a0 [8];
    logic [9:0] a1 [8];
    logic [9:0] a2 [8];

    n_checks  = 0;
    n_fail    = 0;
    bp_mode   = 1'b0;
    rand_gaps = 1'b0;
    rst       = 1'b1;
    ratio_x   = 2'd0;
    ratio_y   = 2'd0;
    avg_en    = 1'b0;
    vi.tdata  = '0;
    vi.tvalid = 1'b0;
    vi.tlast  = 1'b0;
    vi.tuser  = 1'b0;
    vo.tready = 1'b1;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, vo.tvalid}, 32'd0);
    chk("rst_data", vo.tdata, 32'd0);
    chk("rst_last_user", {30'd0, vo.tlast, vo.tuser}, 32'd0);
    chk("rst_ready", {31'd0, vi.tready}, 32'd1);
    rst = 1'b0;
    idle(2);

    // ---------------- passthrough ----------------
    start_test();
    ratio_x = 2'd0; ratio_y = 2'd0; avg_en = 1'b0;
    for (int p = 0; p < 32; p++) begin
      send(pk(10'(p), 10'(p + 100), 10'(p + 300)), (p % 8) == 7, p == 0);
      push_exp(pk(10'(p), 10'(p + 100), 10'(p + 300)), (p % 8) == 7, p == 0);
    end
    finish_test("pass");
    for (int i = 0; i < in_cyc_q.size() && i < out_cyc_q.size(); i++)
      chk($sformatf("pass_latency%0d", i), out_cyc_q[i] - in_cyc_q[i], 32'd1);
    chk("pass_throughput", in_cyc_q[31] - in_cyc_q[0], 32'd31);

    // ---------------- 2x2 drop ----------------
    start_test();
    ratio_x = 2'd1; ratio_y = 2'd1; avg_en = 1'b0;
    frame_2x2();
    finish_test("drop2x2");

    // ---------------- average 4x1 ----------------
    start_test();
    ratio_x = 2'd2; ratio_y = 2'd0; avg_en = 1'b1;
    a0 = '{10'd10, 10'd11, 10'd12, 10'd13, 10'd100, 10'd200, 10'd300, 10'd400};
    a1 = '{10'd1000, 10'd1001, 10'd1002, 10'd1003, 10'd1023, 10'd1023, 10'd1023, 10'd1023};
    a2 = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd5, 10'd5, 10'd5, 10'd6};
    for (int i = 0; i < 8; i++) send(pk(a0[i], a1[i], a2[i]), i == 7, i == 0);
    push_exp(pk(10'd11, 10'd1001, 10'd1), 1'b0, 1'b1);
    push_exp(pk(10'd250, 10'd1023, 10'd5), 1'b1, 1'b0);
    finish_test("avg4");

    // ---------------- partial group, drop then average ----------------
    start_test();
    ratio_x = 2'd2; ratio_y = 2'd0; avg_en = 1'b0;
    for (int p = 0; p < 6; p++) send(pk(10'(p), 10'(p + 20), 10'd0), p == 5, p == 0);
    push_exp(pk(10'd0, 10'd20, 10'd0), 1'b0, 1'b1);
    push_exp(pk(10'd4, 10'd24, 10'd0), 1'b1, 1'b0);
    finish_test("part_drop");

    start_test();
    avg_en = 1'b1;
    for (int p = 0; p < 6; p++) send(pk(10'(p), 10'(p + 20), 10'd0), p == 5, p == 0);
    push_exp(pk(10'd1, 10'd21, 10'd0), 1'b0, 1'b1);
    push_exp(pk(10'd4, 10'd24, 10'd0), 1'b1, 1'b0);
    finish_test("part_avg");

    // ---------------- backpressure ----------------
    start_test();
    ratio_x = 2'd1; ratio_y = 2'd1; avg_en = 1'b0;
    bp_mode   = 1'b1;
    rand_gaps = 1'b1;
    frame_2x2();
    finish_test("bp");
    bp_mode   = 1'b0;
    rand_gaps = 1'b0;
    vo.tready = 1'b1;
    idle(2);

    // ---------------- config applied per frame + saturation ----------------
    start_test();
    ratio_x = 2'd1; ratio_y = 2'd0; avg_en = 1'b0;
    send(pk(10'd0, 10'd1, 10'd2), 1'b0, 1'b1);
    ratio_x = 2'd0;
    avg_en  = 1'b1;
    for (int p = 1; p < 8; p++) send(pk(10'(p), 10'(p + 1), 10'(p + 2)), p == 7, 1'b0);
    for (int p = 0; p < 8; p += 2) push_exp(pk(10'(p), 10'(p + 1), 10'(p + 2)), p == 6, p == 0);
    avg_en = 1'b0;
    for (int p = 10; p < 14; p++) begin
      send(pk(10'(p), 10'(p + 1), 10'(p + 2)), p == 13, p == 10);
      push_exp(pk(10'(p), 10'(p + 1), 10'(p + 2)), p == 13, p == 10);
    end
    ratio_x = 2'd3;
    for (int p = 0; p < 8; p++) send(pk(10'(p), 10'(p + 1), 10'(p + 2)), p == 7, p == 0);
    push_exp(pk(10'd0, 10'd1, 10'd2), 1'b0, 1'b1);
    push_exp(pk(10'd4, 10'd5, 10'd6), 1'b1, 1'b0);
    finish_test("cfg");

    // ---------------- tuser mid-line ----------------
    start_test();
    ratio_x = 2'd1; ratio_y = 2'd0; avg_en = 1'b0;
    send(pk(10'd0, 10'd0, 10'd0), 1'b0, 1'b1);
    send(pk(10'd1, 10'd0, 10'd0), 1'b0, 1'b0);
    send(pk(10'd2, 10'd0, 10'd0), 1'b0, 1'b0);
    send(pk(10'd50, 10'd0, 10'd0), 1'b0, 1'b1);
    send(pk(10'd51, 10'd0, 10'd0), 1'b0, 1'b0);
    send(pk(10'd52, 10'd0, 10'd0), 1'b0, 1'b0);
    send(pk(10'd53, 10'd0, 10'd0), 1'b1, 1'b0);
    push_exp(pk(10'd0, 10'd0, 10'd0), 1'b0, 1'b1);
    push_exp(pk(10'd50, 10'd0, 10'd0), 1'b0, 1'b1);
    push_exp(pk(10'd52, 10'd0, 10'd0), 1'b1, 1'b0);
    finish_test("midsof");

    // ---------------- reset mid-line ----------------
    start_test();
    ratio_x = 2'd1; ratio_y = 2'd0; avg_en = 1'b0;
    vo.tready = 1'b0;
    send(pk(10'd7, 10'd8, 10'd9), 1'b0, 1'b1);
    send(pk(10'd1, 10'd1, 10'd1), 1'b0, 1'b0);
    idle(1);
    chk("pre_rst_valid", {31'd0, vo.tvalid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, vo.tvalid}, 32'd0);
    chk("arst_data", vo.tdata, 32'd0);
    chk("arst_last_user", {30'd0, vo.tlast, vo.tuser}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    vo.tready = 1'b1;
    idle(1);
    start_test();
    for (int p = 0; p < 4; p++) send(pk(10'(p), 10'(p + 1), 10'(p + 2)), p == 3, p == 0);
    push_exp(pk(10'd0, 10'd1, 10'd2), 1'b0, 1'b1);
    push_exp(pk(10'd2, 10'd3, 10'd4), 1'b1, 1'b0);
    finish_test("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/px_subsampler_2d.md
# px_subsampler_2d

Two-dimensional, multi-channel pixel subsampler on an AXI4-Stream video path, one pixel per beat. Horizontal and vertical decimation ratios are independent powers of two. Horizontal reduction is either decimation (drop) or box averaging. Sits between the video source/processing chain and downstream scaler/VDMA stages, and supersedes the single-mode subsampler for multi-ratio pipelines.

## Interface
- CHANNELS_AMOUNT, 3, colour channels per pixel
- PX_WIDTH, 10, bits per channel
- MAX_RATIO_LOG2, 2, max log2 of either ratio (ratio up to 4)
- TDATA_WIDTH, 32, stream width; must be ≥ CHANNELS_AMOUNT*PX_WIDTH
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, asynchronous, active-high
- ratio_x_log2_i  in  $clog2(MAX_RATIO_LOG2+1)  horizontal ratio exponent
- ratio_y_log2_i  in  $clog2(MAX_RATIO_LOG2+1)  vertical ratio exponent
- avg_en_i  in  1  0 = horizontal drop, 1 = horizontal average
- video_i_tdata  in  TDATA_WIDTH  pixel; channel c at [c*PX_WIDTH +: PX_WIDTH]
- video_i_tvalid / video_i_tlast / video_i_tuser  in  1  valid, end of line, start of frame
- video_i_tready  out  1
- video_o_tdata  out  TDATA_WIDTH  subsampled pixel; bits above CHANNELS_AMOUNT*PX_WIDTH are zero
- video_o_tvalid / video_o_tlast / video_o_tuser  out  1
- video_o_tready  in  1

## Operation
- Config is applied per frame. On an accepted beat with tuser=1, ratio_x, ratio_y and avg_en are latched into active registers; that beat is processed with the new values. Values outside 0..MAX_RATIO_LOG2 saturate to MAX_RATIO_LOG2. Changes mid-frame have no effect until the next tuser.
- Counters:
  - x_cnt counts modulo 2^rx; cleared at tlast and at tuser.
  - y_cnt counts lines modulo 2^ry, increments on tlast; cleared by tuser, so frame line 0 is always kept.
- Line kept iff y_cnt==0. Beats of dropped lines are accepted and discarded; they produce no output.
- Group = 2^rx consecutive beats of a kept line. One output per group, emitted on its last beat (x_cnt==2^rx−1) or on tlast if earlier.
- Drop mode: output = first pixel of the group (held in a register).
- Average mode, per channel:
  - Accumulator is PX_WIDTH+MAX_RATIO_LOG2 bits; output = sum >> rx (truncation, no rounding).
  - A partial group closed by tlast emits the first pixel of the group, as in drop mode.
- video_o_tlast = 1 on the output produced by a kept line's input tlast.
- video_o_tuser = 1 on the first output beat after a tuser input. A pending-SOF flag is set on tuser acceptance and cleared on emission.
- rx=ry=0: pure passthrough with one register stage.

## Timing
- Reset (async assert): video_o_tvalid=0, tdata=0, tlast=0, tuser=0; counters, accumulators and pending-SOF cleared; active config = rx 0, ry 0, avg 0. Deassertion is taken synchronously.
- video_i_tready = !video_o_tvalid || video_o_tready, every cycle, for kept and dropped lines alike. No combinational path from video_i_tvalid to video_i_tready.
- Latency: output valid the cycle after acceptance of the group-closing beat.
- Throughput: 1 input beat/cycle with no backpressure.
- Output register holds tdata/tlast/tuser stable while tvalid && !tready. It loads when empty or consumed in the same cycle.
- tuser arriving mid-line (short line): counters and accumulator restart; the unfinished group is discarded without output.
- Reset mid-frame: stream state is lost. Output resumes cleanly at the next tuser; input beats before it are processed with x/y counters from zero.

## Test plan
- Passthrough: rx=ry=0, 8×4 frame of pixels 0..31 → identical 32 beats, each 1 cycle late; tuser on beat 0, tlast on beats 7/15/23/31.
- 2×2 drop: rx=ry=1, 8×4 frame, pixel value = y*8+x → outputs 0,2,4,6,16,18,20,22; tlast on 6 and 22; lines 1 and 3 produce nothing.
- Average 4×1: rx=2, ry=0, avg=1, one channel line 10,11,12,13,100,200,300,400 → outputs 11 (46>>2), 250; other channels averaged independently.
- Partial group: rx=2, drop, 6-pixel line 0..5 → outputs 0, 4; tlast on 4. Avg mode gives 1 (6>>2), 4.
- Backpressure: 2×2 drop with video_o_tready toggling 1010 and random input tvalid gaps → same sequence as the 2×2 drop case, no loss or duplication, outputs stable while stalled.
- Config/reset: ratios change mid-frame → old ratios until next tuser. rst_i pulsed mid-line → outputs zero immediately; next frame correct.
